// File: rtl/ysyx_23060203_scoreboard_if.sv
// rtl/ysyx_23060203_scoreboard_if.sv - issue/writeback/flush/query bundle for the GPR scoreboard
interface ysyx_23060203_scoreboard_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic             wb_valid;
    logic             flush;
    logic [CNT_W-1:0] flush_keep;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             raw1;
    logic             raw2;
    logic [CNT_W-1:0] count;
    logic             empty;

    modport master (
        output issue_valid, issue_rd, wb_valid, flush, flush_keep, rs1, rs2,
        input  issue_ready, raw1, raw2, count, empty
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, flush, flush_keep, rs1, rs2,
        output issue_ready, raw1, raw2, count, empty
    );
endinterface

// File: rtl/ysyx_23060203_scoreboard.sv
// rtl/ysyx_23060203_scoreboard.sv - in-order circular scoreboard of pending GPR writes
module ysyx_23060203_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    ysyx_23060203_scoreboard_if.slave    sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [4:0]       entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic             ready;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [CNT_W-1:0] flush_cnt;
    logic [PTR_W-1:0] flush_tail;
    logic [PTR_W-1:0] idx;
    logic             hit1;
    logic             hit2;

    always_comb begin
        ready         = (cnt < FULL) | sb.wb_valid;
        pop           = sb.wb_valid & (cnt != '0);
        push          = sb.issue_valid & ready & ~sb.flush;
        head_next     = head + PTR_W'(pop);
        cnt_after_pop = cnt - CNT_W'(pop);
        flush_cnt     = (sb.flush_keep < cnt_after_pop) ? sb.flush_keep : cnt_after_pop;
        flush_tail    = head_next + flush_cnt[PTR_W-1:0];

        // Validity is decided by position relative to head, never by stored contents.
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < cnt) begin
                if (entries[idx] == sb.rs1) hit1 = 1'b1;
                if (entries[idx] == sb.rs2) hit2 = 1'b1;
            end
        end
    end

    assign sb.issue_ready = ready;
    assign sb.raw1        = hit1 & (sb.rs1 != 5'd0);
    assign sb.raw2        = hit2 & (sb.rs2 != 5'd0);
    assign sb.count       = cnt;
    assign sb.empty       = (cnt == '0);

    always_ff @(posedge clock) begin
        if (push) begin
            entries[tail] <= sb.issue_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head_next;
            if (sb.flush) begin
                cnt  <= flush_cnt;
                tail <= flush_tail;
            end else begin
                cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
            end
        end
    end
endmodule
